nukv_axis_downsizer: RTL and testbench
======================================

// Module: nukv_axis_downsizer
// PURPOSE
//  Width-down converter on the read side of the async-clock FIFO.
//  Consumes one wide word per handshake from the FIFO master port and emits it as RATIO
//  narrow beats, lowest lane first.
//  Runs entirely in the FIFO read clock domain and feeds narrow pipeline stages
//  (e.g. 64-bit network/hash paths).
//  Full throughput: one narrow beat per clock with no bubble between consecutive wide words.
// PARAMETERS
//  OUT_WIDTH  64  width of one narrow output beat (bits)
//  RATIO      8   narrow beats per wide word; must be >= 2
//                 (IN_WIDTH = OUT_WIDTH*RATIO is a localparam)
// PORTS
//  clk                in   1          single clock (FIFO m_clk domain)
//  rst                in   1          asynchronous, active-high reset
//  s_axis_tdata       in   IN_WIDTH   wide word from FIFO m_axis_tdata
//  s_axis_tlast       in   1          word ends a packet
//  s_axis_tvalid      in   1          wide word valid
//  s_axis_tready      out  1          wide word accepted when tvalid&tready
//  m_axis_tdata       out  OUT_WIDTH  narrow beat
//  m_axis_tlast       out  1          last beat of a packet
//  m_axis_tvalid      out  1          narrow beat valid
//  m_axis_tready      in   1          downstream ready
//  busy               out  1          holding register occupied (debug/status)
// BEHAVIOUR
//  Reset values (asserted asynchronously, released synchronously to clk):
//   - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, lane counter=0.
//   - s_axis_tready=0 while rst=1.
//  State: EMPTY (busy=0) / SHIFT (busy=1).
//   - Registers: holding register hold[IN_WIDTH-1:0], hold_last, lane counter cnt[$clog2(RATIO)-1:0].
//  Outputs:
//   - m_axis_tdata = hold[cnt*OUT_WIDTH +: OUT_WIDTH].
//   - m_axis_tvalid = busy.
//   - m_axis_tlast = busy & hold_last & (cnt==RATIO-1).
//  Ready path:
//   - last_beat = busy & (cnt==RATIO-1) & m_axis_tready.
//   - s_axis_tready = ~rst & (~busy | last_beat); combinational from m_axis_tready, no extra register.
//  EMPTY: on s valid&ready, load hold/hold_last, cnt<=0, go to SHIFT.
//   - First narrow beat is valid on the next cycle (latency 1 clk).
//  SHIFT: on m valid&ready with cnt<RATIO-1, cnt<=cnt+1.
//   - Beat handshake when cnt==RATIO-1:
//     - if a new wide word is accepted the same cycle, reload and stay in SHIFT with cnt<=0 (no bubble);
//     - otherwise go to EMPTY with cnt<=0.
//  Backpressure: with m_axis_tready=0, m_axis_tdata/tlast/tvalid hold stable (AXI-Stream rule).
//   - cnt never advances without a handshake.
//  cnt wraps only through the explicit reload to 0; never exceeds RATIO-1.
//   - RATIO need not be a power of two.
//  s_axis_tdata is never captured while busy & ~last_beat, even if s_axis_tvalid=1.
//  Reset mid-word discards the remaining lanes; no partial beat is emitted after reset.
//  tlast is carried per wide word only; a word with tlast=0 never produces m_axis_tlast=1.
// TESTING
//  1. Single word, lanes 0x00..0x07, tlast=1, m_ready=1:
//     - beats 0x00..0x07 on 8 consecutive cycles starting 1 clk after accept;
//     - tlast only on 0x07; then tvalid=0.
//  2. Back-to-back: 4 words always valid, m_ready=1:
//     - 32 beats with m_axis_tvalid high continuously;
//     - s_axis_tready pulses exactly on every 8th beat.
//  3. Random m_ready (50%), 100 words:
//     - output equals lane-serialised input in order, zero loss/duplication;
//     - data stable whenever tvalid=1 & tready=0.
//  4. Assert rst after beat 3 of a word:
//     - tvalid drops immediately (async), s_ready=0 during reset;
//     - after release the next word starts at lane 0; stale lanes 4..7 never appear.
//  5. RATIO=3, OUT_WIDTH=16, word 0x333322221111, tlast=0:
//     - beats 0x1111, 0x2222, 0x3333, all with tlast=0;
//     - cnt returns to 0.

Source files
------------

// File: rtl/nukv_axis_downsizer_if.sv
// AXI-Stream style bundle (data, last, valid, ready) shared by the wide
// input side and the narrow output side of the downsizer.
interface nukv_axis_downsizer_if #(
    parameter int WIDTH = 64
);
    logic [WIDTH-1:0] tdata;
    logic             tlast;
    logic             tvalid;
    logic             tready;

    modport master (
        output tdata,
        output tlast,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tlast,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/nukv_axis_downsizer.sv
// Width-down converter on the read side of the async FIFO.
// Takes one wide word per handshake and emits RATIO narrow beats, lowest lane
// first, at one beat per clock with no bubble between consecutive wide words.
//
// state    | meaning
// ST_EMPTY | holding register free, waiting for a wide word
// ST_SHIFT | holding register occupied, serialising lanes (busy=1)
module nukv_axis_downsizer #(
    parameter int OUT_WIDTH = 64,
    parameter int RATIO     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    nukv_axis_downsizer_if.slave   s_axis,
    nukv_axis_downsizer_if.master  m_axis,
    output logic                   busy
);
    localparam int IN_WIDTH = OUT_WIDTH * RATIO;
    localparam int CW       = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IN_WIDTH-1:0] r_hold;
    logic                r_hold_last;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_nxt;
    logic                w_load;
    logic                w_busy;
    logic                w_cnt_at_last;
    logic                w_m_fire;
    logic                w_last_beat;
    logic                w_s_ready;
    logic                w_s_fire;
    int                  w_lane_base;

    assign w_busy        = (r_state == ST_SHIFT);
    assign w_cnt_at_last = (r_cnt == LAST_LANE);
    assign w_m_fire      = w_busy & m_axis.tready;
    assign w_last_beat   = w_m_fire & w_cnt_at_last;

    // Ready is combinational from downstream ready so a new word can be taken
    // on the same edge as the final beat of the current one.
    assign w_s_ready = ~rst & (~w_busy | w_last_beat);
    assign w_s_fire  = s_axis.tvalid & w_s_ready;

    assign w_lane_base = int'(r_cnt) * OUT_WIDTH;

    assign s_axis.tready = w_s_ready;
    assign m_axis.tdata  = r_hold[w_lane_base +: OUT_WIDTH];
    assign m_axis.tvalid = w_busy;
    assign m_axis.tlast  = w_busy & r_hold_last & w_cnt_at_last;
    assign busy          = w_busy;

    // Next-state, lane counter and reload decision.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_s_fire) begin
                    w_load      = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_m_fire) begin
                    if (w_cnt_at_last) begin
                        // Counter only ever wraps through this explicit reload,
                        // so non power-of-two ratios never overrun the lanes.
                        w_cnt_nxt = '0;
                        if (w_s_fire) begin
                            w_load      = 1'b1;
                            w_state_nxt = ST_SHIFT;
                        end else begin
                            w_state_nxt = ST_EMPTY;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State and lane counter registers; reset discards any partial word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Holding register, written only when a wide word is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold      <= '0;
            r_hold_last <= 1'b0;
        end else if (w_load) begin
            r_hold      <= s_axis.tdata;
            r_hold_last <= s_axis.tlast;
        end
    end
endmodule

// File: tb/tb_nukv_axis_downsizer.sv
// Directed bench for the AXI-Stream downsizer: default 64x8 instance plus a
// 16x3 instance for the non power-of-two ratio.
module tb_nukv_axis_downsizer;
    logic clk;
    logic rst;
    logic busy0;
    logic busy3;

    int n_tests;
    int n_fail;

    nukv_axis_downsizer_if #(.WIDTH(512)) s_if0 ();
    nukv_axis_downsizer_if #(.WIDTH(64))  m_if0 ();
    nukv_axis_downsizer_if #(.WIDTH(48))  s_if3 ();
    nukv_axis_downsizer_if #(.WIDTH(16))  m_if3 ();

    nukv_axis_downsizer #(.OUT_WIDTH(64), .RATIO(8)) dut0 (
        .clk    (clk),
        .rst    (rst),
        .s_axis (s_if0),
        .m_axis (m_if0),
        .busy   (busy0)
    );

    nukv_axis_downsizer #(.OUT_WIDTH(16), .RATIO(3)) dut3 (
        .clk    (clk),
        .rst    (rst),
        .s_axis (s_if3),
        .m_axis (m_if3),
        .busy   (busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] lanes8(input logic [63:0] base);
        logic [511:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) w[i*64 +: 64] = base + 64'(i);
        return w;
    endfunction

    initial begin
        logic [64:0]  q[$];
        logic [64:0]  e;
        logic [511:0] word;
        logic         acc;
        logic         stall_prev;
        logic [63:0]  prev_data;
        logic         prev_last;
        int           wi;
        int           cyc;

        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        s_if0.tdata = '0; s_if0.tlast = 1'b0; s_if0.tvalid = 1'b0; m_if0.tready = 1'b1;
        s_if3.tdata = '0; s_if3.tlast = 1'b0; s_if3.tvalid = 1'b0; m_if3.tready = 1'b1;

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_tvalid", m_if0.tvalid, 1'b0);
        chk("rst_tlast",  m_if0.tlast, 1'b0);
        chk("rst_tdata",  m_if0.tdata, 64'h0);
        chk("rst_busy",   busy0, 1'b0);
        chk("rst_sready", s_if0.tready, 1'b0);
        rst = 1'b0;
        #1;
        chk("post_rst_sready", s_if0.tready, 1'b1);

        // 1: single word, lanes 0..7, tlast=1
        @(negedge clk);
        s_if0.tdata = lanes8(64'h0); s_if0.tlast = 1'b1; s_if0.tvalid = 1'b1;
        @(negedge clk);
        s_if0.tvalid = 1'b0; s_if0.tlast = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("t1_tvalid", m_if0.tvalid, 1'b1);
            chk("t1_tdata",  m_if0.tdata, 64'(i));
            chk("t1_tlast",  m_if0.tlast, (i == 7));
            @(negedge clk);
        end
        chk("t1_idle_tvalid", m_if0.tvalid, 1'b0);
        chk("t1_idle_busy",   busy0, 1'b0);

        // 2: four back-to-back words, ready pulses on every 8th beat
        wi = 0;
        s_if0.tdata = lanes8(64'h0); s_if0.tlast = 1'b0; s_if0.tvalid = 1'b1;
        @(negedge clk);
        wi = 1;
        s_if0.tdata = lanes8(64'h10); s_if0.tlast = 1'b0;
        for (int b = 0; b < 32; b++) begin
            chk("t2_tvalid", m_if0.tvalid, 1'b1);
            chk("t2_tdata",  m_if0.tdata, 64'((b / 8) * 16 + (b % 8)));
            chk("t2_tlast",  m_if0.tlast, (b == 31));
            chk("t2_sready", s_if0.tready, ((b % 8) == 7));
            acc = s_if0.tvalid & s_if0.tready;
            @(negedge clk);
            if (acc) begin
                wi++;
                if (wi < 4) begin
                    s_if0.tdata = lanes8(64'(wi * 16));
                    s_if0.tlast = (wi == 3);
                end else begin
                    s_if0.tvalid = 1'b0;
                    s_if0.tlast  = 1'b0;
                end
            end
        end
        chk("t2_idle_tvalid", m_if0.tvalid, 1'b0);

        // 3: 100 random words under random downstream ready
        wi = 0;
        q.delete();
        stall_prev = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        for (int i = 0; i < 8; i++) word[i*64 +: 64] = {$urandom, $urandom};
        s_if0.tdata = word; s_if0.tlast = 1'($urandom_range(0, 1)); s_if0.tvalid = 1'b1;
        cyc = 0;
        while (cyc < 5000 && !(wi == 100 && q.size() == 0 && !m_if0.tvalid)) begin
            m_if0.tready = 1'($urandom_range(0, 1));
            #1;
            if (stall_prev) begin
                chk("t3_stall_tvalid", m_if0.tvalid, 1'b1);
                chk("t3_stall_tdata",  m_if0.tdata, prev_data);
                chk("t3_stall_tlast",  m_if0.tlast, prev_last);
            end
            if (m_if0.tvalid && m_if0.tready) begin
                if (q.size() == 0) begin
                    chk("t3_unexpected_beat", 1'b1, 1'b0);
                end else begin
                    e = q.pop_front();
                    chk("t3_tdata", m_if0.tdata, e[63:0]);
                    chk("t3_tlast", m_if0.tlast, e[64]);
                end
            end
            stall_prev = m_if0.tvalid & ~m_if0.tready;
            prev_data  = m_if0.tdata;
            prev_last  = m_if0.tlast;
            acc = s_if0.tvalid & s_if0.tready;
            if (acc) begin
                for (int i = 0; i < 8; i++)
                    q.push_back({s_if0.tlast & (i == 7), s_if0.tdata[i*64 +: 64]});
            end
            @(negedge clk);
            cyc++;
            if (acc) begin
                wi++;
                if (wi < 100) begin
                    for (int i = 0; i < 8; i++) word[i*64 +: 64] = {$urandom, $urandom};
                    s_if0.tdata = word;
                    s_if0.tlast = 1'($urandom_range(0, 1));
                end else begin
                    s_if0.tvalid = 1'b0;
                    s_if0.tlast  = 1'b0;
                end
            end
        end
        chk("t3_timeout", (cyc < 5000), 1'b1);
        chk("t3_words_sent", 32'(wi), 32'd100);
        chk("t3_queue_empty", 32'(q.size()), 32'd0);
        m_if0.tready = 1'b1;

        // 4: reset after beat 3 of a word
        @(negedge clk);
        s_if0.tdata = lanes8(64'hA0); s_if0.tlast = 1'b1; s_if0.tvalid = 1'b1;
        @(negedge clk);
        s_if0.tvalid = 1'b0; s_if0.tlast = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t4_pre_tdata", m_if0.tdata, 64'hA0 + 64'(i));
            @(negedge clk);
        end
        chk("t4_pre_rst_tvalid", m_if0.tvalid, 1'b1);
        rst = 1'b1;
        #1;
        chk("t4_rst_tvalid", m_if0.tvalid, 1'b0);
        chk("t4_rst_tlast",  m_if0.tlast, 1'b0);
        chk("t4_rst_tdata",  m_if0.tdata, 64'h0);
        chk("t4_rst_busy",   busy0, 1'b0);
        s_if0.tdata = lanes8(64'hB0); s_if0.tlast = 1'b0; s_if0.tvalid = 1'b1;
        #1;
        chk("t4_rst_sready", s_if0.tready, 1'b0);
        @(negedge clk);
        chk("t4_rst_no_capture", busy0, 1'b0);
        rst = 1'b0;
        #1;
        chk("t4_rel_sready", s_if0.tready, 1'b1);
        @(negedge clk);
        s_if0.tvalid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("t4_tvalid", m_if0.tvalid, 1'b1);
            chk("t4_tdata",  m_if0.tdata, 64'hB0 + 64'(i));
            chk("t4_tlast",  m_if0.tlast, 1'b0);
            @(negedge clk);
        end
        chk("t4_idle_tvalid", m_if0.tvalid, 1'b0);

        // 5: RATIO=3, OUT_WIDTH=16, tlast=0
        s_if3.tdata = 48'h3333_2222_1111; s_if3.tlast = 1'b0; s_if3.tvalid = 1'b1;
        #1;
        chk("t5_sready", s_if3.tready, 1'b1);
        @(negedge clk);
        s_if3.tvalid = 1'b0;
        chk("t5_b0_tdata", m_if3.tdata, 16'h1111);
        chk("t5_b0_tlast", m_if3.tlast, 1'b0);
        chk("t5_b0_tvalid", m_if3.tvalid, 1'b1);
        @(negedge clk);
        chk("t5_b1_tdata", m_if3.tdata, 16'h2222);
        chk("t5_b1_tlast", m_if3.tlast, 1'b0);
        @(negedge clk);
        chk("t5_b2_tdata", m_if3.tdata, 16'h3333);
        chk("t5_b2_tlast", m_if3.tlast, 1'b0);
        chk("t5_b2_sready", s_if3.tready, 1'b1);
        @(negedge clk);
        chk("t5_idle_tvalid", m_if3.tvalid, 1'b0);
        chk("t5_idle_busy",   busy3, 1'b0);
        chk("t5_lane0_again", m_if3.tdata, 16'h1111);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
